// File: rtl/request_arbiter_16_pkg.sv
// rtl/request_arbiter_16_pkg.sv - shared constants, state encoding and helpers for request_arbiter_16
package request_arbiter_16_pkg;

    localparam int N     = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Index of the set bit in a one-hot vector; zero input yields index 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/request_arbiter_16_rr_pick16.sv
// rtl/request_arbiter_16_rr_pick16.sv - combinational round-robin pick of the first request at or after ptr
module rr_pick16
    import request_arbiter_16_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             any
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        // Scan ptr, ptr+1, ... with the 4-bit index wrapping 15 -> 0.
        for (int k = 0; k < N; k++) begin
            idx = ptr + IDX_W'(k);
            if (req[idx] && !found) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/request_arbiter_16.sv
// rtl/request_arbiter_16.sv - edge-capturing round-robin request arbiter with registered one-hot grant
module request_arbiter_16 #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [N-1:0] in16,
    input  logic         ack,
    output logic [N-1:0] onehot16,
    output logic         valid,
    output logic [N-1:0] pending16,
    output logic         overflow
);

    import request_arbiter_16_pkg::*;

    state_t           state;
    logic [N-1:0]     in_q;
    logic [IDX_W-1:0] ptr;

    logic [N-1:0]     gnt;
    logic             any;
    logic             select;
    logic [N-1:0]     rise_en;
    logic [N-1:0]     clr;
    logic [N-1:0]     pending_nxt;
    logic             ovf_hit;

    rr_pick16 u_pick (
        .req (pending16),
        .ptr (ptr),
        .gnt (gnt),
        .any (any)
    );

    always_comb begin
        select  = (state == IDLE) && enable && any;
        rise_en = enable ? (in16 & ~in_q) : '0;
        clr     = select ? gnt : '0;
        // A new edge on the line being granted re-arms it; it is not a lost edge.
        pending_nxt = (pending16 & ~clr) | rise_en;
        ovf_hit     = |(rise_en & pending16 & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_q      <= '0;
            ptr       <= '0;
            onehot16  <= '0;
            valid     <= 1'b0;
            pending16 <= '0;
            overflow  <= 1'b0;
        end else begin
            in_q      <= in16;
            pending16 <= pending_nxt;
            overflow  <= overflow | ovf_hit;
            case (state)
                IDLE: begin
                    if (select) begin
                        onehot16 <= gnt;
                        valid    <= 1'b1;
                        state    <= OFFER;
                    end
                end
                OFFER: begin
                    if (ack) begin
                        onehot16 <= '0;
                        valid    <= 1'b0;
                        ptr      <= onehot_to_idx(onehot16) + IDX_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_request_arbiter_16.sv
// tb/tb_request_arbiter_16.sv - scoreboard-driven self-checking bench for request_arbiter_16
module tb_request_arbiter_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] in16;
    logic        ack;
    logic [15:0] onehot16;
    logic        valid;
    logic [15:0] pending16;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    request_arbiter_16 #(.N(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in16      (in16),
        .ack       (ack),
        .onehot16  (onehot16),
        .valid     (valid),
        .pending16 (pending16),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles, output int cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b0;
        while (!valid && cycles < max_cycles) begin
            tick();
            cycles++;
        end
        if (!valid) timed_out = 1'b1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; ack = 1'b0; in16 = '0; enable = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; ack = 1'b0; in16 = 16'hFFFF;
        repeat (2) tick();
        n_checks++;
        if ({onehot16, valid, pending16, overflow} !== 34'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got onehot=%h valid=%b pending=%h ovf=%b, want all 0", onehot16, valid, pending16, overflow);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (pending16 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_release_pending: got %h want ffff", pending16);
        end
        do_reset(2);
    endtask

    task automatic test_single();
        int cyc; bit to; logic [15:0] e;
        do_reset(2);
        in16 = 16'h8000;
        exp_q.push_back(16'h8000);
        wait_valid(10, cyc, to);
        n_checks++;
        if (to || cyc != 2) begin
            n_fail++;
            $display("FAIL single_latency: got %0d edges (timeout=%0b) want 2", cyc, to);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (onehot16 !== e) begin
            n_fail++;
            $display("FAIL single_grant: got %h want %h", onehot16, e);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (valid !== 1'b1 || onehot16 !== e) begin
                n_fail++;
                $display("FAIL single_hold[%0d]: got valid=%b onehot=%h want 1/%h", i, valid, onehot16, e);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || onehot16 !== 16'h0 || dut.ptr !== 4'd0) begin
            n_fail++;
            $display("FAIL single_ack: got valid=%b onehot=%h ptr=%0d want 0/0000/0", valid, onehot16, dut.ptr);
        end
        in16 = '0;
    endtask

    task automatic test_round_robin();
        int cyc; bit to; logic [15:0] e;
        do_reset(2);
        in16 = 16'h4005;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h4000);
        while (exp_q.size() > 0) begin
            wait_valid(10, cyc, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || onehot16 !== e) begin
                n_fail++;
                $display("FAIL rr_grant: got %h (timeout=%0b) want %h", onehot16, to, e);
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
            n_checks++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_gap: got valid=%b want 0", valid);
            end
        end
        in16 = '0;
    endtask

    task automatic test_enable_gating();
        int cyc; bit to; logic [15:0] e;
        do_reset(2);
        enable = 1'b0;
        in16   = 16'h4000;
        repeat (3) tick();
        n_checks++;
        if (pending16 !== 16'h0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_off: got pending=%h valid=%b want 0000/0", pending16, valid);
        end
        enable = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (pending16 !== 16'h0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_held_high: got pending=%h valid=%b want 0000/0", pending16, valid);
        end
        in16 = '0;
        tick();
        in16 = 16'h4000;
        exp_q.push_back(16'h4000);
        wait_valid(10, cyc, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || onehot16 !== e) begin
            n_fail++;
            $display("FAIL enable_fresh_rise: got %h (timeout=%0b) want %h", onehot16, to, e);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        in16 = '0;
    endtask

    task automatic test_overflow();
        int cyc; bit to; logic [15:0] e;
        do_reset(2);
        in16 = 16'h0001;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0010);
        wait_valid(10, cyc, to);
        in16 = 16'h0011; tick();
        in16 = 16'h0001; tick();
        n_checks++;
        if (overflow !== 1'b0 || pending16 !== 16'h0010) begin
            n_fail++;
            $display("FAIL ovf_first_rise: got ovf=%b pending=%h want 0/0010", overflow, pending16);
        end
        in16 = 16'h0011; tick();
        n_checks++;
        if (overflow !== 1'b1 || pending16 !== 16'h0010) begin
            n_fail++;
            $display("FAIL ovf_second_rise: got ovf=%b pending=%h want 1/0010", overflow, pending16);
        end
        while (exp_q.size() > 0) begin
            wait_valid(10, cyc, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || onehot16 !== e) begin
                n_fail++;
                $display("FAIL ovf_grant: got %h (timeout=%0b) want %h", onehot16, to, e);
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end
        repeat (3) tick();
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_cleared_by_reset: got %b want 0", overflow);
        end
        in16 = '0;
    endtask

    task automatic test_mid_offer_reset();
        int cyc; bit to; logic [15:0] e;
        do_reset(2);
        in16 = 16'h0800;
        exp_q.push_back(16'h0800);
        wait_valid(10, cyc, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || onehot16 !== e) begin
            n_fail++;
            $display("FAIL mid_reset_grant: got %h (timeout=%0b) want %h", onehot16, to, e);
        end
        rst = 1'b1; in16 = '0;
        tick();
        rst = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || onehot16 !== 16'h0 || pending16 !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset_drop: got valid=%b onehot=%h pending=%h want 0/0000/0000", valid, onehot16, pending16);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_after: got valid=%b want 0", valid);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; in16 = '0; ack = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_enable_gating();
        test_overflow();
        test_mid_offer_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/request_arbiter_16.md
REQUEST_ARBITER_16 -- requirements
Module: request_arbiter_16

Interface
REQ-001 The module SHALL have the parameter N, default 16, meaning the number of request lines; this release supports only N=16.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port enable, input, 1 bit: 1 = capture request edges and issue new grants; 0 = capture and new grants are suspended.
REQ-005 The module SHALL have port in16, input, 16 bits: level request lines, synchronous to clk.
REQ-006 The module SHALL have port ack, input, 1 bit: the downstream encoder stage has consumed the current grant.
REQ-007 The module SHALL have port onehot16, output, 16 bits: registered grant, which is one-hot while valid=1 and all-zero otherwise; it feeds the 16-to-4 encoder in16 input.
REQ-008 The module SHALL have port valid, output, 1 bit: registered; onehot16 holds a grant.
REQ-009 The module SHALL have port pending16, output, 16 bits: registered; requests captured but not yet granted.
REQ-010 The module SHALL have port overflow, output, 1 bit: registered sticky flag; a request edge was lost.

Function
REQ-011 An internal register in_q SHALL hold in16 from the previous cycle; in_q SHALL update every cycle regardless of enable.
REQ-012 A rising edge on line i SHALL be (in16[i]=1 and in_q[i]=0); with enable=1 it SHALL set pending16[i] at that clock edge.
REQ-013 With enable=0, rising edges SHALL be discarded; pending16 SHALL hold its value.
REQ-014 A rising edge on a line whose pending16 bit is already 1 SHALL set overflow; pending16 is unchanged.
REQ-015 The state machine SHALL have two states, IDLE and OFFER.
REQ-016 In IDLE with enable=1 and pending16!=0, the block SHALL select the first set pending bit at index ptr, ptr+1, ... wrapping 15->0.
REQ-017 On that selection edge: onehot16 <= the selected bit; valid <= 1; the selected pending16 bit is cleared; state -> OFFER.
REQ-018 A rising edge on the selected line at that same edge SHALL re-set its pending bit (set takes priority over clear) without setting overflow.
REQ-019 Latency from a request to its grant: in16[i] first sampled high at edge N sets pending; valid=1 and onehot16[i]=1 SHALL appear after edge N+1 if the block is in IDLE and no other request is ahead.
REQ-020 In OFFER, onehot16 and valid SHALL hold stable while ack=0, whatever the value of enable.
REQ-021 In OFFER with ack=1: valid <= 0; onehot16 <= 0; ptr <= (granted index + 1) mod 16; state -> IDLE.
REQ-022 At least one IDLE cycle (valid=0) SHALL separate consecutive grants.
REQ-023 ack SHALL be ignored in IDLE.
REQ-024 ptr SHALL be 4 bits and wrap naturally.
REQ-025 The block SHALL have no combinational path from any input to any output.

Reset
REQ-026 On rst=1 at a clock edge the block SHALL set: onehot16=0, valid=0, pending16=0, overflow=0, in_q=0, ptr=0, state=IDLE; rst overrides all other inputs.
REQ-027 Reset mid-OFFER SHALL drop the grant; the cycle after reset, valid SHALL be 0.
REQ-028 A line held high through reset release SHALL count as one rising edge on the first non-reset cycle (because in_q=0).

Structure
REQ-029 A shared package SHALL hold the constants N=16 and IDX_W=4 and the state encoding (IDLE=0, OFFER=1).
REQ-030 The round-robin pick SHALL be a combinational sub-module rr_pick16 with inputs req[15:0] and ptr[3:0] and outputs gnt[15:0] and any.
REQ-031 Total RTL SHALL be 120-400 lines.

Verification
REQ-032 Reset: rst=1 for 2 cycles with in16=16'hFFFF -> all outputs 0; one cycle after release, pending16=16'hFFFF.
REQ-033 Single request: in16=16'h8000, enable=1, ack=0 -> valid=1 and onehot16=16'h8000 two edges after the rise, held for 5 cycles; ack=1 for 1 cycle -> valid=0 and ptr=0.
REQ-034 Round robin: pending 16'h4005 with ptr=0 and ack pulsed once each grant -> grant order 16'h0001, 16'h0004, 16'h4000, with valid=0 between grants.
REQ-035 Enable gating: enable=0 with a rise of 16'h4000 -> pending16 stays 0 and valid stays 0; with enable=1 and the line held high, there is no grant until a fresh rise.
REQ-036 Overflow: 16'h0010 toggled 0-1-0-1 while pending and ungranted -> overflow=1 and remains 1 until rst.
REQ-037 Mid-offer reset: valid=1 with onehot16=16'h0800, then rst for 1 cycle -> valid=0, onehot16=0, pending16=0.
